thirtytwo_bit_adder: RTL and testbench
======================================

Name: thirtytwo_bit_adder

Overview:
- Registered 32-bit ripple-carry adder/subtractor for the ALU add/sub path of the 32-bit MIPS datapath.
- Computes A+B+Cin or A−B−Cin, selected by Sub, and produces a carry-out.
- Result and carry are captured in output registers, one clock after the inputs are presented.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- Sub  input  1  0 = add, 1 = subtract.
- Sum  output  WIDTH  registered result.
- Cout  output  1  registered carry-out of the MSB stage.

Behaviour:
- Combinational core:
  - B_eff = B XOR {WIDTH{Sub}}.
  - c0 = Cin XOR Sub.
  - {carry, result} = A + B_eff + c0, computed as a WIDTH-stage ripple chain of full-adder cells.
- Add mode (Sub=0): result = (A+B+Cin) mod 2^WIDTH; Cout = bit WIDTH of the true sum.
- Subtract mode (Sub=1): result = (A−B−Cin) mod 2^WIDTH.
  - Cout is the raw carry-out: 1 = no borrow (A ≥ B+Cin), 0 = borrow.
- Registers: on a rising clk with rst_n=1, Sum←result and Cout←carry. Latency is exactly 1 cycle.
- Inputs are sampled every cycle; there is no handshake or enable.
- Reset: on a rising clk with rst_n=0, Sum←0 and Cout←0.
  - Reset overrides any inputs in that cycle.
  - Deasserting reset resumes normal capture on the next edge.
  - Reset asserted mid-stream discards the in-flight result.
- Wrap-around: all-ones + 1 with Sub=0 gives Sum=0, Cout=1.
- Subtracting equal operands gives Sum=0, Cout=1.
- 0 − 1 gives Sum=all-ones, Cout=0.
- Operands are unsigned. No saturation; results always wrap.
- Sum and Cout hold their value between edges. No X propagation from known inputs.

Optional Feature:
- Macro ADDER_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port Ovf (1 bit, registered alongside Sum).
  - Ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Reset value of Ovf is 0.
- When undefined: Ovf does not exist, and Sum/Cout behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - ADDER_WIDTH = 32.
  - Mode constants ADD_MODE = 1'b0 and SUB_MODE = 1'b1.
  - A typedef for the WIDTH-bit data word.
- One sub-module, full_adder_cell: a 1-bit full adder (a, b, cin → s, cout).
  - Instantiated WIDTH times with a generate loop to form the ripple chain.
  - The top level adds the B-inversion, the carry-in XOR and the output registers.

Test Plan:
- Reset: hold rst_n=0 with A=5, B=7 for 2 cycles → Sum=0, Cout=0. Release → next cycle Sum=12, Cout=0.
- Add sweep, Sub=0, Cin=0:
  - 2+6 → 8.
  - 1504+4120 → 5624.
  - 65535+1 → 65536.
  - 65535+65153 → 130688.
  - All with Cout=0, each appearing one cycle after stimulus.
- Add carry/wrap: A=4294967295, B=1, Cin=0 → Sum=0, Cout=1. A=0, B=0, Cin=1 → Sum=1.
- Subtract sweep, Sub=1, Cin=0:
  - 6−3 → 3.
  - 15031−108 → 14923 (B given as octal 154).
  - 65535−65153 → 382.
  - 429496729−1 → 429496728.
  - All with Cout=1.
- Borrow cases, Sub=1:
  - A=0, B=1, Cin=0 → Sum=4294967295, Cout=0.
  - A=10, B=4, Cin=1 → Sum=5, Cout=1.
  - A=7, B=7, Cin=0 → Sum=0, Cout=1.
- With ADDER_OVERFLOW_FLAG_EN defined:
  - 0x7FFFFFFF+1 (add) → Ovf=1.
  - 0x80000000−1 (sub) → Ovf=1.
  - 3+4 → Ovf=0.
  - Back-to-back changing inputs each cycle → outputs track with exactly 1-cycle lag.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder/subtractor.
// Width, mode encodings and the data-word type used by the ALU add/sub path.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    localparam logic ADD_MODE = 1'b0;
    localparam logic SUB_MODE = 1'b1;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the building block of the ripple carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/thirtytwo_bit_adder.sv
// Registered ripple-carry add/sub, one cycle latency, synchronous active-low reset.
// Define ADDER_OVERFLOW_FLAG_EN to add the registered signed-overflow output Ovf.
module thirtytwo_bit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef ADDER_OVERFLOW_FLAG_EN
    ,
    output logic             Ovf
`endif
);

    logic             w_sub;
    logic [WIDTH-1:0] w_beff;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_result;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Subtraction is A + ~B + 1; a borrow-in removes that +1.
    assign w_sub      = (Sub == SUB_MODE);
    assign w_beff     = B ^ {WIDTH{w_sub}};
    assign w_carry[0] = Cin ^ w_sub;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chain
        full_adder_cell u_fa (
            .a    (A[g]),
            .b    (w_beff[g]),
            .cin  (w_carry[g]),
            .s    (w_result[g]),
            .cout (w_carry[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_result;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;

`ifdef ADDER_OVERFLOW_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_thirtytwo_bit_adder.sv
// Bench for thirtytwo_bit_adder: arithmetic model checked every cycle plus
// directed vectors with literal expectations; Ovf checks when ADDER_OVERFLOW_FLAG_EN.
module tb_thirtytwo_bit_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        Sub;
    logic [31:0] Sum;
    logic        Cout;
`ifdef ADDER_OVERFLOW_FLAG_EN
    logic        Ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    thirtytwo_bit_adder #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sub   (Sub),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef ADDER_OVERFLOW_FLAG_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the inputs seen at each edge.
    logic [31:0] m_sum;
    logic        m_cout;
    logic        m_ovf;

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, input logic rn);
        longint ua, ub, sa, sb64, u, s;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb64 = longint'($signed(b));
        if (!rn) begin
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (!sb) begin
            u      = ua + ub + longint'(ci);
            s      = sa + sb64 + longint'(ci);
            m_sum  = u[31:0];
            m_cout = (u >= 64'sd4294967296);
            m_ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            u      = ua - ub - longint'(ci);
            s      = sa - sb64 - longint'(ci);
            m_sum  = u[31:0];
            m_cout = (ua >= ub + longint'(ci));
            m_ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
    endtask

    always begin
        @(posedge clk);
        model(A, B, Cin, Sub, rst_n);
        #1;
        check("model_sum", longint'(Sum), longint'(m_sum));
        check("model_cout", longint'(Cout), longint'(m_cout));
`ifdef ADDER_OVERFLOW_FLAG_EN
        check("model_ovf", longint'(Ovf), longint'(m_ovf));
`endif
    end

    // Drive at a falling edge, then check one cycle later against literals.
    task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb,
                       input logic [31:0] es, input logic ec);
        A   = a;
        B   = b;
        Cin = ci;
        Sub = sb;
        @(negedge clk);
        check({name, "_sum"}, longint'(Sum), longint'(es));
        check({name, "_cout"}, longint'(Cout), longint'(ec));
    endtask

`ifdef ADDER_OVERFLOW_FLAG_EN
    task automatic vec_ovf(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb, input logic eo);
        A   = a;
        B   = b;
        Cin = ci;
        Sub = sb;
        @(negedge clk);
        check({name, "_ovf"}, longint'(Ovf), longint'(eo));
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        A     = 32'd5;
        B     = 32'd7;
        Cin   = 1'b0;
        Sub   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum", longint'(Sum), 0);
        check("rst_cout", longint'(Cout), 0);
        rst_n = 1'b1;
        vec("rel", 32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0);

        vec("add0", 32'd2, 32'd6, 1'b0, 1'b0, 32'd8, 1'b0);
        vec("add1", 32'd1504, 32'd4120, 1'b0, 1'b0, 32'd5624, 1'b0);
        vec("add2", 32'd65535, 32'd1, 1'b0, 1'b0, 32'd65536, 1'b0);
        vec("add3", 32'd65535, 32'd65153, 1'b0, 1'b0, 32'd130688, 1'b0);
        vec("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1);
        vec("cin", 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0);

        vec("sub0", 32'd6, 32'd3, 1'b0, 1'b1, 32'd3, 1'b1);
        vec("sub1", 32'd15031, 32'o154, 1'b0, 1'b1, 32'd14923, 1'b1);
        vec("sub2", 32'd65535, 32'd65153, 1'b0, 1'b1, 32'd382, 1'b1);
        vec("sub3", 32'd429496729, 32'd1, 1'b0, 1'b1, 32'd429496728, 1'b1);

        vec("brw0", 32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        vec("brw1", 32'd10, 32'd4, 1'b1, 1'b1, 32'd5, 1'b1);
        vec("eq", 32'd7, 32'd7, 1'b0, 1'b1, 32'd0, 1'b1);

        // Reset mid-stream discards the in-flight result, then capture resumes.
        rst_n = 1'b0;
        vec("mrst", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
        vec("resume", 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0);

`ifdef ADDER_OVERFLOW_FLAG_EN
        vec_ovf("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
        vec_ovf("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1);
        vec_ovf("ovf_none", 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
`endif

        // Back-to-back changing inputs; the per-cycle model checks the 1-cycle lag.
        for (int i = 0; i < 60; i++) begin
            A   = $urandom;
            B   = (i % 4 == 0) ? A : $urandom;
            Cin = 1'($urandom_range(0, 1));
            Sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
